// File: rtl/alu_entry_sequencer_pkg.sv
// Shared constants and helpers for the ALU front-panel entry sequencer.
package alu_seq_pkg;

    // Coarse decode of the state index; PH_BAD covers unused encodings.
    typedef enum logic [2:0] {
        PH_OPND,
        PH_OP,
        PH_EXEC,
        PH_SHOW,
        PH_BAD
    } phase_t;

    function automatic int st_opnd0();
        return 0;
    endfunction

    function automatic int st_op(input int n);
        return n;
    endfunction

    function automatic int st_exec(input int n);
        return n + 1;
    endfunction

    function automatic int st_show(input int n);
        return n + 2;
    endfunction

    // Counter width able to hold 0..t-1 (at least one bit).
    function automatic int tmo_w(input int t);
        return (t <= 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/alu_entry_sequencer_edge_rise_detect.sv
// Rising-edge detector for a synchronised button level; one pulse per 0->1 edge.
module edge_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic r_q;

    // Remember last cycle's level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= 1'b0;
        else      r_q <= level;
    end

    // Pulse is forced low while reset is asserted.
    assign pulse = level & ~r_q & rst;

endmodule

// File: rtl/alu_entry_sequencer.sv
// Operand/opcode entry sequencer: N operand loads, opcode, execute handshake, result display.
module alu_entry_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int NUM_OPERANDS = 2,
    parameter  int TIMEOUT      = 255,
    localparam int STATE_W      = $clog2(NUM_OPERANDS + 3)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enter,
    input  logic                    reuse,
    input  logic                    cancel,
    input  logic                    op_valid,
    input  logic                    exec_done,
    output logic [NUM_OPERANDS-1:0] load_en,
    output logic                    sel_reuse,
    output logic                    load_op,
    output logic                    exec_start,
    output logic                    busy,
    output logic [STATE_W-1:0]      state,
    output logic                    result_held,
    output logic                    timeout_err
);

    localparam int CNT_W = tmo_w(TIMEOUT);

    localparam logic [STATE_W-1:0] S_OPND0 = STATE_W'(st_opnd0());
    localparam logic [STATE_W-1:0] S_OPND1 = STATE_W'(st_opnd0() + 1);
    localparam logic [STATE_W-1:0] S_OP    = STATE_W'(st_op(NUM_OPERANDS));
    localparam logic [STATE_W-1:0] S_EXEC  = STATE_W'(st_exec(NUM_OPERANDS));
    localparam logic [STATE_W-1:0] S_SHOW  = STATE_W'(st_show(NUM_OPERANDS));
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0]      r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_exec_start;
    logic                    r_result_held;
    logic                    r_timeout_err;

    logic                    w_enter_pulse;
    phase_t                  w_phase;
    logic [STATE_W-1:0]      w_state_nxt;
    logic [NUM_OPERANDS-1:0] w_load_en;
    logic                    w_sel_reuse;
    logic                    w_load_op;
    logic                    w_set_held;
    logic                    w_tmo;

    edge_rise_detect u_enter_edge (
        .clk   (clk),
        .rst   (rst),
        .level (enter),
        .pulse (w_enter_pulse)
    );

    // Map the state index onto its phase.
    always_comb begin
        w_phase = PH_BAD;
        if (r_state < S_OP)        w_phase = PH_OPND;
        else if (r_state == S_OP)  w_phase = PH_OP;
        else if (r_state == S_EXEC) w_phase = PH_EXEC;
        else if (r_state == S_SHOW) w_phase = PH_SHOW;
    end

    // Next state and load strobes; one event per cycle, cancel first, then exec result, reuse, enter.
    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = '0;
        w_sel_reuse = 1'b0;
        w_load_op   = 1'b0;
        w_set_held  = 1'b0;
        w_tmo       = 1'b0;
        if (rst) begin
            if (cancel) begin
                w_state_nxt = S_OPND0;
            end else begin
                case (w_phase)
                    PH_OPND: begin
                        if (r_state == S_OPND0 && reuse && r_result_held) begin
                            w_sel_reuse = 1'b1;
                            w_load_en   = NUM_OPERANDS'(1);
                            w_state_nxt = r_state + STATE_W'(1);
                        end else if (w_enter_pulse) begin
                            w_load_en   = NUM_OPERANDS'(1) << r_state;
                            w_state_nxt = r_state + STATE_W'(1);
                        end
                    end
                    PH_OP: begin
                        if (w_enter_pulse && op_valid) begin
                            w_load_op   = 1'b1;
                            w_state_nxt = S_EXEC;
                        end
                    end
                    PH_EXEC: begin
                        if (exec_done) begin
                            w_set_held  = 1'b1;
                            w_state_nxt = S_SHOW;
                        end else if (r_cnt == CNT_LAST) begin
                            w_tmo       = 1'b1;
                            w_state_nxt = S_OPND0;
                        end
                    end
                    PH_SHOW: begin
                        if (reuse) begin
                            // Chain the held result straight into operand 0.
                            w_sel_reuse = 1'b1;
                            w_load_en   = NUM_OPERANDS'(1);
                            w_state_nxt = S_OPND1;
                        end else if (w_enter_pulse) begin
                            w_state_nxt = S_OPND0;
                        end
                    end
                    default: w_state_nxt = S_OPND0;
                endcase
            end
        end
    end

    // State, exec counter and registered status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_OPND0;
            r_cnt         <= '0;
            r_exec_start  <= 1'b0;
            r_result_held <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= (r_state == S_EXEC && w_state_nxt == S_EXEC) ? r_cnt + CNT_W'(1) : '0;
            r_exec_start  <= (w_state_nxt == S_EXEC) && (r_state != S_EXEC);
            r_timeout_err <= w_tmo;
            if (w_set_held)  r_result_held <= 1'b1;
            else if (w_tmo)  r_result_held <= 1'b0;
        end
    end

    assign load_en     = w_load_en;
    assign sel_reuse   = w_sel_reuse;
    assign load_op     = w_load_op;
    assign exec_start  = r_exec_start;
    assign busy        = (r_state == S_EXEC);
    assign state       = r_state;
    assign result_held = r_result_held;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed bench for alu_entry_sequencer with NUM_OPERANDS=2, TIMEOUT=4.
// States: 0 OPND0, 1 OPND1, 2 OP, 3 EXEC, 4 SHOW.
module tb_alu_entry_sequencer;

    logic       clk;
    logic       rst;
    logic       enter, reuse, cancel, op_valid, exec_done;
    logic [1:0] load_en;
    logic       sel_reuse, load_op, exec_start, busy, result_held, timeout_err;
    logic [2:0] state;

    int n_chk;
    int n_fail;
    int pulses;

    alu_entry_sequencer #(.NUM_OPERANDS(2), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enter       (enter),
        .reuse       (reuse),
        .cancel      (cancel),
        .op_valid    (op_valid),
        .exec_done   (exec_done),
        .load_en     (load_en),
        .sel_reuse   (sel_reuse),
        .load_op     (load_op),
        .exec_start  (exec_start),
        .busy        (busy),
        .state       (state),
        .result_held (result_held),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Produce one enter edge that is consumed by the following clock edge.
    task automatic edge_enter();
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // From OPND0 walk into the first EXEC cycle.
    task automatic go_exec();
        edge_enter();
        edge_enter();
        op_valid = 1'b1;
        edge_enter();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; enter = 1'b0; reuse = 1'b0; cancel = 1'b0;
        op_valid = 1'b0; exec_done = 1'b0;

        // Reset state, with enter high to confirm loads stay gated.
        #2;
        enter = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_load_en", 32'(load_en), 0);
        chk("rst_held", 32'(result_held), 0);
        chk("rst_exec_start", 32'(exec_start), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_busy", 32'(busy), 0);
        enter = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Test 1: full sequence, exec_done in EXEC cycle 3.
        enter = 1'b1; #1;
        chk("t1_load_en0", 32'(load_en), 1);
        chk("t1_sel_reuse0", 32'(sel_reuse), 0);
        tick();
        chk("t1_state1", 32'(state), 1);
        enter = 1'b0; tick();
        enter = 1'b1; #1;
        chk("t1_load_en1", 32'(load_en), 2);
        tick();
        chk("t1_state2", 32'(state), 2);
        enter = 1'b0; tick();
        op_valid = 1'b1; enter = 1'b1; #1;
        chk("t1_load_op", 32'(load_op), 1);
        chk("t1_load_en_op", 32'(load_en), 0);
        tick();
        chk("t1_state3", 32'(state), 3);
        chk("t1_exec_start", 32'(exec_start), 1);
        chk("t1_busy", 32'(busy), 1);
        enter = 1'b0;
        tick();
        chk("t1_exec_start_c2", 32'(exec_start), 0);
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("t1_state4", 32'(state), 4);
        chk("t1_held", 32'(result_held), 1);
        chk("t1_busy_show", 32'(busy), 0);
        chk("t1_no_tmo", 32'(timeout_err), 0);

        // Test 4: reuse in SHOW chains into operand 0.
        reuse = 1'b1; #1;
        chk("t4_sel_reuse", 32'(sel_reuse), 1);
        chk("t4_load_en", 32'(load_en), 1);
        tick();
        reuse = 1'b0;
        chk("t4_state", 32'(state), 1);

        // Test 6a: cancel in OPND1 with an enter edge present.
        cancel = 1'b1; enter = 1'b1; #1;
        chk("t6_load_en", 32'(load_en), 0);
        tick();
        cancel = 1'b0;
        chk("t6_state", 32'(state), 0);
        chk("t6_held_kept", 32'(result_held), 1);
        enter = 1'b0; tick();

        // Test 2: enter held high for 10 cycles gives a single load.
        enter = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (load_en != 2'b00) pulses++;
            tick();
        end
        chk("t2_pulses", 32'(pulses), 1);
        chk("t2_state", 32'(state), 1);
        enter = 1'b0; tick();

        // Test 3: opcode gate.
        edge_enter();
        chk("t3_state_op", 32'(state), 2);
        op_valid = 1'b0;
        tick();
        enter = 1'b1; #1;
        chk("t3_no_load_op", 32'(load_op), 0);
        tick();
        chk("t3_stay_op", 32'(state), 2);
        enter = 1'b0; tick();
        op_valid = 1'b1; enter = 1'b1; #1;
        chk("t3_load_op", 32'(load_op), 1);
        tick();
        chk("t3_state_exec", 32'(state), 3);
        enter = 1'b0;

        // Test 5: timeout after four EXEC cycles.
        tick(); tick(); tick();
        chk("t5_c4_state", 32'(state), 3);
        chk("t5_c4_tmo", 32'(timeout_err), 0);
        tick();
        chk("t5_tmo_pulse", 32'(timeout_err), 1);
        chk("t5_state0", 32'(state), 0);
        chk("t5_held_clr", 32'(result_held), 0);
        tick();
        chk("t5_tmo_1cyc", 32'(timeout_err), 0);

        // Reuse with no held result is ignored.
        reuse = 1'b1; #1;
        chk("nr_load_en", 32'(load_en), 0);
        chk("nr_sel_reuse", 32'(sel_reuse), 0);
        tick();
        reuse = 1'b0;
        chk("nr_state", 32'(state), 0);

        // Test 5 variant: exec_done on the final count beats the timeout.
        go_exec();
        tick(); tick(); tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("t5v_state", 32'(state), 4);
        chk("t5v_no_tmo", 32'(timeout_err), 0);
        chk("t5v_held", 32'(result_held), 1);

        // Enter in SHOW returns to OPND0 without loads.
        enter = 1'b1; #1;
        chk("sh_load_en", 32'(load_en), 0);
        tick();
        enter = 1'b0;
        chk("sh_state", 32'(state), 0);

        // Reuse in OPND0 with a held result.
        reuse = 1'b1; #1;
        chk("r0_sel_reuse", 32'(sel_reuse), 1);
        chk("r0_load_en", 32'(load_en), 1);
        tick();
        reuse = 1'b0;
        chk("r0_state", 32'(state), 1);

        // Test 6b: asynchronous reset in the middle of EXEC.
        edge_enter();
        edge_enter();
        tick();
        chk("t6b_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6b_state", 32'(state), 0);
        chk("t6b_busy0", 32'(busy), 0);
        chk("t6b_exec_start", 32'(exec_start), 0);
        chk("t6b_held", 32'(result_held), 0);
        chk("t6b_load_en", 32'(load_en), 0);
        tick();
        rst = 1'b1;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("t6b_late_done", 32'(state), 0);
        chk("t6b_late_held", 32'(result_held), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
